seq_recognizer: RTL and testbench

Parametrised serial pattern recognizer for one-bit input streams. It keeps a sliding history of the last `W` accepted bits and compares it against a runtime-loadable pattern of programmable length. It flags each match with a registered one-cycle pulse and supports overlapping and non-overlapping detection. It is the generalised replacement for the fixed-pattern recognizer FSMs used in the lab datapath.

---
 rtl/seq_recognizer.sv | 115 +++++++++++
 tb/tb_seq_recognizer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_recognizer.sv
// seq_recognizer: serial pattern recognizer over a W-bit sliding history.
// The runtime pattern is loadable and its length is programmable.
// Matching can be overlapping or non-overlapping.
// Optional saturating match counter, built only when SEQ_RECOGNIZER_MATCH_CNT_EN is defined.
// Without the macro, match_cnt is tied to 0 and cnt_clr is ignored.
module seq_recognizer #(
  parameter int             W               = 8,
  parameter logic [W-1:0]   DEFAULT_PATTERN = 'b0000_1010,
  parameter int             DEFAULT_LEN     = 4,
  parameter int             CNT_W           = 16,
  localparam int            LW              = $clog2(W+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LW-1:0] W_L = LW'(W);

  logic [W-1:0]  hist_q, hist_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic          out_q, out_d;

  logic [W-1:0]  mask;
  logic [W-1:0]  h_shift;
  logic [LW-1:0] f_nxt;
  logic          hit;
  logic          fire;

  // Compare mask: bit i is active when it lies inside the current pattern length.
  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) mask[i] = (i < int'(len_q));
  end

  assign h_shift = {hist_q[W-2:0], in};
  assign f_nxt   = (fill_q == W_L) ? fill_q : fill_q + LW'(1);
  // A match needs enough fresh bits, and the newest len bits must equal the pattern.
  assign hit     = (len_q != '0) && (f_nxt >= len_q) && (((h_shift ^ pat_q) & mask) == '0);

  // Next-state rules: a config load outranks a stream bit, which outranks idle.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    out_d  = 1'b0;
    fire   = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > W_L) ? W_L : cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = h_shift;
      out_d  = hit;
      fire   = hit;
      // Non-overlapping mode restarts the fill count, so the next match must be built from fresh bits.
      fill_d = (hit && !overlap) ? '0 : f_nxt;
    end
  end

  // History, pattern and match-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEFAULT_PATTERN;
      len_q  <= LW'(DEFAULT_LEN);
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef SEQ_RECOGNIZER_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter; a clear on the same edge as a match takes priority.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                      cnt_d = '0;
    else if (fire && (cnt_q != '1))   cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_clr ^ fire;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_recognizer.sv
// Self-checking bench for seq_recognizer.
// Two instances share every input: one with default parameters, one with CNT_W=2.
// A queue-based reference model predicts out and match_cnt for each cycle.
module tb_seq_recognizer;
  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_bit = 1'b0, overlap = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
  logic [W-1:0]  cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          out_a, out_b;
  logic [15:0]   cnt_a;
  logic [1:0]    cnt_b;

  always #5 clk = ~clk;

  seq_recognizer dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .out(out_a), .match_cnt(cnt_a));

  seq_recognizer #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .out(out_b), .match_cnt(cnt_b));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the accepted bits that may still contribute to a match, oldest first.
  bit           hq[$];
  logic [W-1:0] m_pat;
  int           m_len;
  bit           m_out;
  int           m_cnt_a, m_cnt_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    hq.delete();
    m_pat   = 8'b0000_1010;
    m_len   = 4;
    m_out   = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // Apply one clock edge to the model, using the inputs as they stood before that edge.
  task automatic m_edge();
    bit hit;
    hit = 1'b0;
    if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > W) ? W : int'(cfg_len);
      hq.delete();
      m_out = 1'b0;
    end else if (in_valid) begin
      hq.push_back(in_bit);
      if (hq.size() > W) void'(hq.pop_front());
      if (m_len > 0 && hq.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (hq[hq.size()-1-i] != m_pat[i]) hit = 1'b0;
      end
      m_out = hit;
      if (hit && !overlap) hq.delete();
    end else begin
      m_out = 1'b0;
    end
    if (cnt_clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 3)     m_cnt_b++;
    end
  endtask

  task automatic compare_all();
    int ea, eb;
`ifdef SEQ_RECOGNIZER_MATCH_CNT_EN
    ea = m_cnt_a;
    eb = m_cnt_b;
`else
    ea = 0;
    eb = 0;
`endif
    chk("out_a", 32'(out_a), 32'(m_out));
    chk("out_b", 32'(out_b), 32'(m_out));
    chk("cnt_a", 32'(cnt_a), ea);
    chk("cnt_b", 32'(cnt_b), eb);
  endtask

  task automatic cyc(input logic vld, input logic b, input logic ld = 1'b0,
                     input logic [W-1:0] pat = '0, input logic [LW-1:0] len = '0,
                     input logic clr = 1'b0);
    in_valid = vld; in_bit = b; cfg_load = ld; cfg_pattern = pat; cfg_len = len; cnt_clr = clr;
    @(posedge clk);
    m_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i]);
  endtask

  initial begin
    m_reset();
    #12 compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: default pattern 1010, overlapping
    overlap = 1'b1;
    send(32'b101010, 6);
    cyc(1'b0, 1'b0);

    // 2: non-overlapping
    do_reset();
    overlap = 1'b0;
    send(32'b101010, 6);

    // 3: gaps, then a reset in the middle of a sequence
    do_reset();
    send(32'b10, 2);
    repeat (3) cyc(1'b0, 1'b0);
    send(32'b10, 2);
    send(32'b101, 3);
    do_reset();
    send(32'b0, 1);

    // 4: full-width reload with a dropped same-edge bit, then length 0
    cyc(1'b1, 1'b1, 1'b1, 8'b1111_0000, 4'd8);
    send(32'b1111_0000, 8);
    cyc(1'b0, 1'b0, 1'b1, 8'b0000_0000, 4'd0);
    send(32'hA5F0_0F5A, 32);

    // 5: counter saturation (CNT_W=2) and a clear on the same edge as a match
    overlap = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 8'b0000_0001, 4'd1);
    send(32'b11111, 5);
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 1'b1);

    // length above W is clamped to W
    cyc(1'b0, 1'b0, 1'b1, 8'b1010_1010, 4'd13);
    send(32'b1010_1010_1010, 12);

    // randomized mix of stream bits, reloads, clears, overlap changes and resets
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) overlap = 1'($urandom);
      if (r == 0) begin
        do_reset();
      end else if (r < 3) begin
        int l;
        l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
        cyc(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 4'(l), 1'($urandom_range(0, 3) == 0));
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, '0, '0,
            1'($urandom_range(0, 49) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
